hci_latency_monitor: RTL and testbench
======================================

// Module: hci_latency_monitor
// PURPOSE
// - Synthesizable per-channel latency monitor for HCI core target ports (req/gnt/wen/r_valid).
// - Parametrised in channel count, outstanding-read depth and counter widths.
// - Tracks pipelined reads in order and accumulates count/sum/min/max latency per channel.
// - Sits beside the interconnect in verif benches and in-silicon perf counters; purely observational.
// PARAMETERS
// - N_CH        4   number of monitored channels (masters)
// - MAX_OUTST   4   max outstanding granted reads per channel (timestamp FIFO depth, >=1)
// - TS_W        16  timestamp / per-transaction latency width
// - CNT_W       32  width of txn count and latency sum accumulators
// - MEAS_WRITES 1   1: writes contribute samples; 0: writes are ignored
// PORTS
// - clk          in   1             clock
// - rst          in   1             asynchronous reset, active-high
// - clear_i      in   1             sync clear of statistics and sticky flags (FIFOs kept)
// - enable_i     in   1             1: completions accumulate; 0: tracking runs, stats frozen
// - req_i        in   N_CH          per-channel HCI req
// - gnt_i        in   N_CH          per-channel HCI gnt
// - wen_i        in   N_CH          per-channel HCI wen (1 = read, 0 = write)
// - r_valid_i    in   N_CH          per-channel HCI r_valid
// - txn_cnt_o    out  N_CH x CNT_W  completed sampled transactions
// - lat_sum_o    out  N_CH x CNT_W  sum of sampled latencies (saturating)
// - lat_min_o    out  N_CH x TS_W   minimum sampled latency
// - lat_max_o    out  N_CH x TS_W   maximum sampled latency
// - outst_o      out  N_CH x $clog2(MAX_OUTST+1)  reads granted awaiting r_valid
// - err_ovf_o    out  N_CH          sticky: read gnt while FIFO full
// - err_unexp_o  out  N_CH          sticky: r_valid with FIFO empty
// - sat_o        out  N_CH          sticky: lat_sum_o or txn_cnt_o saturated
// BEHAVIOUR
// - Reset: cnt/sum/max = 0, min = all-ones, outst = 0, all flags 0, FIFOs empty, ts = 0.
// - Free-running TS_W timestamp `ts` per monitor, increments every cycle, wraps modulo 2^TS_W.
// - Request start: first cycle req_i=1 with no pending start captures `t0 = ts`.
//   - Held until gnt. A req that drops without gnt discards t0 (no sample).
// - Write (gnt & !wen): latency = ts - t0 + 1 (req+gnt same cycle -> 1). Completes that cycle.
// - Read (gnt & wen):
//   - Push t0 into the channel FIFO.
//   - On each r_valid, pop the head; latency = ts - head + 1.
//   - Responses are in order.
// - Back-to-back: gnt in cycle N with req still high in N+1 starts a new t0 in N+1.
// - Simultaneous in one cycle:
//   - Write completion + read r_valid: both sampled; cnt += 2, sum += both, min/max over both.
//   - Read gnt + r_valid: pop before push. A full FIFO is not an overflow in this case.
// - Full FIFO:
//   - Read gnt without a same-cycle r_valid sets err_ovf.
//   - The new t0 is dropped; its later r_valid pops the next entry (stats thereafter unreliable).
// - r_valid with empty FIFO: set err_unexp, no sample, FIFO unchanged.
// - Latency width: modular TS_W subtraction. Latency >= 2^TS_W aliases (documented limit).
// - Accumulation: only when enable_i=1 and, for writes, MEAS_WRITES=1.
//   - Sum saturates at 2^CNT_W-1; count saturates likewise; either saturation sets sat_o.
// - Output timing: stats outputs are registered; a completion in cycle N is visible from N+1.
// - clear_i:
//   - Resets stats and sticky flags to their reset values in the next cycle.
//   - Completions in the clear cycle are discarded.
//   - FIFOs, outst_o and t0 are unaffected, so in-flight reads are measured correctly.
// - rst mid-operation: everything returns to reset values immediately; pending reads are lost.
// TESTING
// - Write, req+gnt same cycle, ch0 -> cnt=1, sum=1, min=max=1 one cycle later.
// - Read, req 3 cycles before gnt, r_valid 2 cycles after gnt -> latency 6; outst_o 1 -> 0.
// - 4 reads granted back-to-back on ch1, r_valid each 3 cycles later:
//   - cnt=4, sum=16, min=max=4, outst peaks at 3.
// - MAX_OUTST=2: 3 reads granted, no r_valid -> err_ovf=1 on 3rd gnt; spurious r_valid on idle ch2 -> err_unexp=1.
// - Write completion and read r_valid same cycle on ch3 (lat 1 and 5) -> cnt += 2, sum += 6, min=1, max=5.
// - clear_i with 2 reads outstanding, then 2 r_valids:
//   - Stats restart at 0, min=all-ones until first sample.
//   - Latencies are measured from the original t0.

Source files
------------

// File: rtl/hci_mon_if.sv
// Observation bundle for the HCI target-port handshake: one bit per channel for each signal.
// The master side drives the bundle and the latency monitor observes it through the slave side.
interface hci_mon_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] req;
  logic [N_CH-1:0] gnt;
  logic [N_CH-1:0] wen;
  logic [N_CH-1:0] r_valid;

  modport master (output req, gnt, wen, r_valid);
  modport slave  (input  req, gnt, wen, r_valid);
endinterface

// File: rtl/hci_latency_monitor.sv
// Per-channel HCI latency monitor: timestamps request starts, tracks in-order reads in a small FIFO
// and accumulates count/sum/min/max latency. Purely observational; it drives nothing back to the bus.
module hci_latency_monitor #(
  parameter  int N_CH        = 4,
  parameter  int MAX_OUTST   = 4,
  parameter  int TS_W        = 16,
  parameter  int CNT_W       = 32,
  parameter  int MEAS_WRITES = 1,
  localparam int OW          = $clog2(MAX_OUTST + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_i,
  input  logic                       enable_i,
  hci_mon_if.slave                   hci,
  output logic [N_CH-1:0][CNT_W-1:0] txn_cnt_o,
  output logic [N_CH-1:0][CNT_W-1:0] lat_sum_o,
  output logic [N_CH-1:0][TS_W-1:0]  lat_min_o,
  output logic [N_CH-1:0][TS_W-1:0]  lat_max_o,
  output logic [N_CH-1:0][OW-1:0]    outst_o,
  output logic [N_CH-1:0]            err_ovf_o,
  output logic [N_CH-1:0]            err_unexp_o,
  output logic [N_CH-1:0]            sat_o
);
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  // Sum is formed wide enough that two max-width latencies can never wrap before the saturation test.
  localparam int SW = ((CNT_W > TS_W) ? CNT_W : TS_W) + 2;

  logic [TS_W-1:0] ts;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts <= '0;
    else     ts <= ts + TS_W'(1);
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [TS_W-1:0]  t0, start_ts, head, lat_w, lat_r, min_nx, max_nx;
    logic             pend, wr_done, rd_gnt, pop, push, full, empty, smp_w, smp_r;
    logic             cnt_sat, sum_sat;
    logic [TS_W-1:0]  fifo [MAX_OUTST];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [OW-1:0]    count;
    logic [CNT_W+1:0] cnt_ext;
    logic [SW-1:0]    sum_ext;
    logic [CNT_W-1:0] cnt_q, sum_q;
    logic [TS_W-1:0]  min_q, max_q;
    logic             ovf_q, unexp_q, sat_q;

    always_comb begin
      start_ts = pend ? t0 : ts;
      wr_done  = hci.req[c] & hci.gnt[c] & ~hci.wen[c];
      rd_gnt   = hci.req[c] & hci.gnt[c] &  hci.wen[c];
      empty    = (count == '0);
      full     = (count == OW'(MAX_OUTST));
      // Pop before push: a full FIFO still accepts a grant when a response leaves in the same cycle.
      pop      = hci.r_valid[c] & ~empty;
      push     = rd_gnt & (~full | pop);
      head     = fifo[rd_ptr];
      lat_w    = ts - start_ts + TS_W'(1);
      lat_r    = ts - head + TS_W'(1);
      smp_w    = enable_i & wr_done & (MEAS_WRITES != 0);
      smp_r    = enable_i & pop;
      cnt_ext  = (CNT_W+2)'(cnt_q) + (CNT_W+2)'(smp_w) + (CNT_W+2)'(smp_r);
      sum_ext  = SW'(sum_q) + (smp_w ? SW'(lat_w) : '0) + (smp_r ? SW'(lat_r) : '0);
      cnt_sat  = (cnt_ext[CNT_W+1:CNT_W] != '0);
      sum_sat  = (sum_ext[SW-1:CNT_W] != '0);
      // NOTE: blocking assignments here chain the two candidate samples in one pass; safe only in comb logic.
      min_nx   = min_q;
      max_nx   = max_q;
      if (smp_w && lat_w < min_nx) min_nx = lat_w;
      if (smp_r && lat_r < min_nx) min_nx = lat_r;
      if (smp_w && lat_w > max_nx) max_nx = lat_w;
      if (smp_r && lat_r > max_nx) max_nx = lat_r;
    end

    // NOTE: non-blocking assignments for all state so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pend   <= 1'b0;
        t0     <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (!hci.req[c] || hci.gnt[c]) begin
          pend <= 1'b0;
        end else if (!pend) begin
          pend <= 1'b1;
          t0   <= ts;
        end
        if (pop)  rd_ptr <= (rd_ptr == PW'(MAX_OUTST - 1)) ? '0 : rd_ptr + PW'(1);
        if (push) wr_ptr <= (wr_ptr == PW'(MAX_OUTST - 1)) ? '0 : wr_ptr + PW'(1);
        if (push && !pop)      count <= count + OW'(1);
        else if (pop && !push) count <= count - OW'(1);
      end
    end

    // NOTE: timestamp storage has no reset; occupancy and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
      if (push) fifo[wr_ptr] <= start_ts;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q   <= '0;
        sum_q   <= '0;
        min_q   <= '1;
        max_q   <= '0;
        ovf_q   <= 1'b0;
        unexp_q <= 1'b0;
        sat_q   <= 1'b0;
      end else if (clear_i) begin
        cnt_q   <= '0;
        sum_q   <= '0;
        min_q   <= '1;
        max_q   <= '0;
        ovf_q   <= 1'b0;
        unexp_q <= 1'b0;
        sat_q   <= 1'b0;
      end else begin
        cnt_q <= cnt_sat ? '1 : cnt_ext[CNT_W-1:0];
        sum_q <= sum_sat ? '1 : sum_ext[CNT_W-1:0];
        min_q <= min_nx;
        max_q <= max_nx;
        if (cnt_sat || sum_sat)          sat_q   <= 1'b1;
        if (rd_gnt && full && !hci.r_valid[c]) ovf_q <= 1'b1;
        if (hci.r_valid[c] && empty)     unexp_q <= 1'b1;
      end
    end

    assign txn_cnt_o[c]   = cnt_q;
    assign lat_sum_o[c]   = sum_q;
    assign lat_min_o[c]   = min_q;
    assign lat_max_o[c]   = max_q;
    assign outst_o[c]     = count;
    assign err_ovf_o[c]   = ovf_q;
    assign err_unexp_o[c] = unexp_q;
    assign sat_o[c]       = sat_q;
  end
endmodule

// File: tb/tb_hci_latency_monitor.sv
// Directed bench for hci_latency_monitor: a default instance plus a MAX_OUTST=2 / CNT_W=4 instance
// for overflow and saturation; each scenario task computes its expected values by hand.
module tb_hci_latency_monitor;
  localparam int N_CH = 4;

  logic clk = 1'b0;
  logic rst, clear, enable;
  int   total = 0;
  int   bad   = 0;

  hci_mon_if #(.N_CH(N_CH)) bus  ();
  hci_mon_if #(.N_CH(N_CH)) bus2 ();

  logic [N_CH-1:0][31:0] txn_cnt, lat_sum;
  logic [N_CH-1:0][15:0] lat_min, lat_max;
  logic [N_CH-1:0][2:0]  outst;
  logic [N_CH-1:0]       err_ovf, err_unexp, sat;

  logic [N_CH-1:0][3:0]  txn_cnt2, lat_sum2;
  logic [N_CH-1:0][15:0] lat_min2, lat_max2;
  logic [N_CH-1:0][1:0]  outst2;
  logic [N_CH-1:0]       err_ovf2, err_unexp2, sat2;

  hci_latency_monitor #(.N_CH(N_CH)) dut (
    .clk(clk), .rst(rst), .clear_i(clear), .enable_i(enable), .hci(bus),
    .txn_cnt_o(txn_cnt), .lat_sum_o(lat_sum), .lat_min_o(lat_min), .lat_max_o(lat_max),
    .outst_o(outst), .err_ovf_o(err_ovf), .err_unexp_o(err_unexp), .sat_o(sat)
  );

  hci_latency_monitor #(.N_CH(N_CH), .MAX_OUTST(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .clear_i(clear), .enable_i(enable), .hci(bus2),
    .txn_cnt_o(txn_cnt2), .lat_sum_o(lat_sum2), .lat_min_o(lat_min2), .lat_max_o(lat_max2),
    .outst_o(outst2), .err_ovf_o(err_ovf2), .err_unexp_o(err_unexp2), .sat_o(sat2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req = '0;  bus.gnt = '0;  bus.wen = '0;  bus.r_valid = '0;
    bus2.req = '0; bus2.gnt = '0; bus2.wen = '0; bus2.r_valid = '0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (txn_cnt !== '0) begin bad++; $display("FAIL reset_cnt: got %h want 0", txn_cnt); end
    total++; if (lat_sum !== '0) begin bad++; $display("FAIL reset_sum: got %h want 0", lat_sum); end
    total++; if (lat_min !== {N_CH{16'hffff}}) begin bad++; $display("FAIL reset_min: got %h want all ones", lat_min); end
    total++; if (lat_max !== '0) begin bad++; $display("FAIL reset_max: got %h want 0", lat_max); end
    total++; if (outst !== '0) begin bad++; $display("FAIL reset_outst: got %h want 0", outst); end
    total++; if ({err_ovf, err_unexp, sat} !== '0) begin bad++; $display("FAIL reset_flags: got %b want 0", {err_ovf, err_unexp, sat}); end
  endtask

  task automatic test_write();
    bus.req[0] = 1'b1; bus.gnt[0] = 1'b1; bus.wen[0] = 1'b0;
    tick(); idle();
    total++; if (txn_cnt[0] !== 32'd1) begin bad++; $display("FAIL write_cnt: got %0d want 1", txn_cnt[0]); end
    total++; if (lat_sum[0] !== 32'd1) begin bad++; $display("FAIL write_sum: got %0d want 1", lat_sum[0]); end
    total++; if (lat_min[0] !== 16'd1 || lat_max[0] !== 16'd1) begin bad++; $display("FAIL write_minmax: got %0d/%0d want 1/1", lat_min[0], lat_max[0]); end
  endtask

  task automatic test_read();
    pulse_clear();
    bus.req[0] = 1'b1; bus.wen[0] = 1'b1;
    repeat (3) tick();
    bus.gnt[0] = 1'b1;
    tick(); idle();
    total++; if (outst[0] !== 3'd1) begin bad++; $display("FAIL read_outst_gnt: got %0d want 1", outst[0]); end
    tick();
    bus.r_valid[0] = 1'b1;
    tick(); idle();
    total++; if (outst[0] !== 3'd0) begin bad++; $display("FAIL read_outst_done: got %0d want 0", outst[0]); end
    total++; if (txn_cnt[0] !== 32'd1 || lat_sum[0] !== 32'd6) begin bad++; $display("FAIL read_cnt_sum: got %0d/%0d want 1/6", txn_cnt[0], lat_sum[0]); end
    total++; if (lat_min[0] !== 16'd6 || lat_max[0] !== 16'd6) begin bad++; $display("FAIL read_minmax: got %0d/%0d want 6/6", lat_min[0], lat_max[0]); end
  endtask

  task automatic test_back_to_back();
    int peak = 0;
    pulse_clear();
    for (int k = 0; k < 7; k++) begin
      bus.req[1] = (k < 4); bus.gnt[1] = (k < 4); bus.wen[1] = 1'b1; bus.r_valid[1] = (k >= 3);
      tick();
      if (int'(outst[1]) > peak) peak = int'(outst[1]);
    end
    idle();
    total++; if (peak != 3) begin bad++; $display("FAIL b2b_peak: got %0d want 3", peak); end
    total++; if (outst[1] !== 3'd0) begin bad++; $display("FAIL b2b_outst: got %0d want 0", outst[1]); end
    total++; if (txn_cnt[1] !== 32'd4 || lat_sum[1] !== 32'd16) begin bad++; $display("FAIL b2b_cnt_sum: got %0d/%0d want 4/16", txn_cnt[1], lat_sum[1]); end
    total++; if (lat_min[1] !== 16'd4 || lat_max[1] !== 16'd4) begin bad++; $display("FAIL b2b_minmax: got %0d/%0d want 4/4", lat_min[1], lat_max[1]); end
  endtask

  task automatic test_simultaneous();
    pulse_clear();
    bus.req[3] = 1'b1; bus.gnt[3] = 1'b1; bus.wen[3] = 1'b1;
    tick(); idle();
    repeat (3) tick();
    bus.req[3] = 1'b1; bus.gnt[3] = 1'b1; bus.wen[3] = 1'b0; bus.r_valid[3] = 1'b1;
    tick(); idle();
    total++; if (txn_cnt[3] !== 32'd2 || lat_sum[3] !== 32'd6) begin bad++; $display("FAIL simul_cnt_sum: got %0d/%0d want 2/6", txn_cnt[3], lat_sum[3]); end
    total++; if (lat_min[3] !== 16'd1 || lat_max[3] !== 16'd5) begin bad++; $display("FAIL simul_minmax: got %0d/%0d want 1/5", lat_min[3], lat_max[3]); end
  endtask

  task automatic test_req_abort();
    pulse_clear();
    bus.req[0] = 1'b1;
    repeat (2) tick();
    bus.req[0] = 1'b0;
    tick();
    bus.req[0] = 1'b1; bus.gnt[0] = 1'b1;
    tick(); idle();
    total++; if (txn_cnt[0] !== 32'd1 || lat_max[0] !== 16'd1) begin bad++; $display("FAIL abort_lat: got cnt %0d max %0d want 1/1", txn_cnt[0], lat_max[0]); end
  endtask

  task automatic test_enable();
    pulse_clear();
    enable = 1'b0;
    bus.req[2] = 1'b1; bus.gnt[2] = 1'b1; bus.wen[2] = 1'b0;
    tick();
    bus.wen[2] = 1'b1;
    tick(); idle();
    total++; if (txn_cnt[2] !== 32'd0 || lat_min[2] !== 16'hffff) begin bad++; $display("FAIL enable_frozen: got cnt %0d min %h want 0/ffff", txn_cnt[2], lat_min[2]); end
    total++; if (outst[2] !== 3'd1) begin bad++; $display("FAIL enable_tracking: got %0d want 1", outst[2]); end
    enable = 1'b1;
    tick();
    bus.r_valid[2] = 1'b1;
    tick(); idle();
    total++; if (txn_cnt[2] !== 32'd1 || lat_sum[2] !== 32'd3) begin bad++; $display("FAIL enable_resume: got %0d/%0d want 1/3", txn_cnt[2], lat_sum[2]); end
  endtask

  task automatic test_clear();
    pulse_clear();
    bus.r_valid[2] = 1'b1;
    tick(); idle();
    bus.req[2] = 1'b1; bus.gnt[2] = 1'b1; bus.wen[2] = 1'b0;
    tick(); idle();
    total++; if (err_unexp[2] !== 1'b1 || txn_cnt[2] !== 32'd1) begin bad++; $display("FAIL clear_setup: got unexp %b cnt %0d want 1/1", err_unexp[2], txn_cnt[2]); end
    bus.req[2] = 1'b1; bus.gnt[2] = 1'b1; bus.wen[2] = 1'b1;
    repeat (2) tick();
    idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++; if (txn_cnt[2] !== 32'd0 || lat_sum[2] !== 32'd0) begin bad++; $display("FAIL clear_stats: got %0d/%0d want 0/0", txn_cnt[2], lat_sum[2]); end
    total++; if (lat_min[2] !== 16'hffff || lat_max[2] !== 16'd0) begin bad++; $display("FAIL clear_minmax: got %h/%h want ffff/0", lat_min[2], lat_max[2]); end
    total++; if (err_unexp[2] !== 1'b0) begin bad++; $display("FAIL clear_flag: got %b want 0", err_unexp[2]); end
    total++; if (outst[2] !== 3'd2) begin bad++; $display("FAIL clear_outst: got %0d want 2", outst[2]); end
    bus.r_valid[2] = 1'b1;
    tick(); idle();
    tick();
    bus.r_valid[2] = 1'b1;
    tick(); idle();
    total++; if (txn_cnt[2] !== 32'd2 || lat_sum[2] !== 32'd9) begin bad++; $display("FAIL clear_after_cnt_sum: got %0d/%0d want 2/9", txn_cnt[2], lat_sum[2]); end
    total++; if (lat_min[2] !== 16'd4 || lat_max[2] !== 16'd5) begin bad++; $display("FAIL clear_after_minmax: got %0d/%0d want 4/5", lat_min[2], lat_max[2]); end
  endtask

  task automatic test_overflow();
    bus2.req[0] = 1'b1; bus2.gnt[0] = 1'b1; bus2.wen[0] = 1'b1;
    repeat (2) tick();
    total++; if (err_ovf2 !== 4'b0000 || outst2[0] !== 2'd2) begin bad++; $display("FAIL ovf_before: got ovf %b outst %0d want 0000/2", err_ovf2, outst2[0]); end
    tick(); idle();
    total++; if (err_ovf2 !== 4'b0001 || outst2[0] !== 2'd2) begin bad++; $display("FAIL ovf_set: got ovf %b outst %0d want 0001/2", err_ovf2, outst2[0]); end
    bus2.r_valid[2] = 1'b1;
    tick(); idle();
    total++; if (err_unexp2 !== 4'b0100) begin bad++; $display("FAIL unexp_set: got %b want 0100", err_unexp2); end
    total++; if (txn_cnt2[2] !== 4'd0 || err_ovf2 !== 4'b0001) begin bad++; $display("FAIL unexp_nosample: got cnt %0d ovf %b want 0/0001", txn_cnt2[2], err_ovf2); end
  endtask

  task automatic test_saturation();
    bus2.req[1] = 1'b1; bus2.gnt[1] = 1'b1; bus2.wen[1] = 1'b0;
    repeat (15) tick();
    total++; if (txn_cnt2[1] !== 4'd15 || sat2 !== 4'b0000) begin bad++; $display("FAIL sat_edge: got cnt %0d sat %b want 15/0000", txn_cnt2[1], sat2); end
    tick(); idle();
    total++; if (txn_cnt2[1] !== 4'd15 || lat_sum2[1] !== 4'd15) begin bad++; $display("FAIL sat_hold: got %0d/%0d want 15/15", txn_cnt2[1], lat_sum2[1]); end
    total++; if (sat2 !== 4'b0010) begin bad++; $display("FAIL sat_flag: got %b want 0010", sat2); end
  endtask

  task automatic test_async_reset();
    bus.req[0] = 1'b1; bus.gnt[0] = 1'b1; bus.wen[0] = 1'b1;
    tick(); idle();
    total++; if (outst[0] !== 3'd1) begin bad++; $display("FAIL areset_setup: got %0d want 1", outst[0]); end
    #3 rst = 1'b1;
    #1;
    total++; if (outst !== '0 || txn_cnt !== '0) begin bad++; $display("FAIL areset_immediate: got outst %h cnt %h want 0/0", outst, txn_cnt); end
    total++; if (lat_min !== {N_CH{16'hffff}} || err_ovf2 !== '0 || sat2 !== '0) begin bad++; $display("FAIL areset_values: got min %h ovf2 %b sat2 %b", lat_min, err_ovf2, sat2); end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; enable = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_simultaneous();
    test_req_abort();
    test_enable();
    test_clear();
    test_overflow();
    test_saturation();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
